physical_regfile_mp: RTL and testbench

Parametrised multi-port physical register file for the RCU. It is the successor to the fixed 48-entry, 4-read/4-write regfile, with configurable depth, data width and port counts. It adds same-cycle write-to-read bypass, deterministic write-conflict priority, a hardwired zero register, and a per-register ready scoreboard. The scoreboard is cleared on rename allocation and set on writeback, which lets issue logic query operand readiness directly.

---
 rtl/physical_regfile_mp.sv | 114 +++++++++++
 tb/tb_physical_regfile_mp.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/physical_regfile_mp.sv
`default_nettype none
// physical_regfile_mp: parametrised multi-port physical register file with
// same-cycle write bypass, hardwired zero register and per-register ready scoreboard.
module physical_regfile_mp #(
  parameter int REG_SIZE       = 48,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int XLEN           = 64,
  parameter int RD_PORTS       = 4,
  parameter int WR_PORTS       = 4,
  parameter int ALLOC_PORTS    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [RD_PORTS*REG_SIZE_WIDTH-1:0]  rd_addr_i,
  output logic [RD_PORTS*XLEN-1:0]            rd_data_o,
  output logic [RD_PORTS-1:0]                 rd_ready_o,
  input  logic [WR_PORTS-1:0]                 wr_valid_i,
  input  logic [WR_PORTS*REG_SIZE_WIDTH-1:0]  wr_addr_i,
  input  logic [WR_PORTS*XLEN-1:0]            wr_data_i,
  input  logic [ALLOC_PORTS-1:0]              alloc_valid_i,
  input  logic [ALLOC_PORTS*REG_SIZE_WIDTH-1:0] alloc_addr_i,
  input  logic                                flush_i,
  output logic                                wr_conflict_o
);

  localparam int W = REG_SIZE_WIDTH;
  localparam logic [REG_SIZE_WIDTH:0] REG_LIMIT = (REG_SIZE_WIDTH+1)'(REG_SIZE);

  logic [XLEN-1:0]     mem [REG_SIZE];
  logic [REG_SIZE-1:0] ready;
  logic                conflict;
  logic                conflict_next;

  function automatic logic writable(input logic [REG_SIZE_WIDTH-1:0] addr);
    return (addr != '0) && ({1'b0, addr} < REG_LIMIT);
  endfunction

  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < WR_PORTS; i++) begin
      for (int j = i + 1; j < WR_PORTS; j++) begin
        if (wr_valid_i[i] && wr_valid_i[j] &&
            (wr_addr_i[i*W +: W] == wr_addr_i[j*W +: W]) &&
            (wr_addr_i[i*W +: W] != '0)) begin
          conflict_next = 1'b1;
        end
      end
    end
  end

  // Later non-blocking assignments win: ports are walked high-to-low so the
  // lowest index lands last, then alloc overrides writeback and flush overrides alloc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < REG_SIZE; e++) begin
        mem[e] <= '0;
      end
      ready    <= '1;
      conflict <= 1'b0;
    end else begin
      for (int p = WR_PORTS - 1; p >= 0; p--) begin
        if (wr_valid_i[p] && writable(wr_addr_i[p*W +: W])) begin
          mem[wr_addr_i[p*W +: W]]   <= wr_data_i[p*XLEN +: XLEN];
          ready[wr_addr_i[p*W +: W]] <= 1'b1;
        end
      end
      for (int a = 0; a < ALLOC_PORTS; a++) begin
        if (alloc_valid_i[a] && writable(alloc_addr_i[a*W +: W])) begin
          ready[alloc_addr_i[a*W +: W]] <= 1'b0;
        end
      end
      if (flush_i) begin
        ready <= '1;
      end
      conflict <= conflict_next;
    end
  end

  assign wr_conflict_o = conflict;

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [W-1:0]    addr;
    logic [XLEN-1:0] data;
    logic            rdy;

    assign addr = rd_addr_i[k*W +: W];

    // Bypass is suppressed while reset is asserted so outputs fall back to
    // reset values immediately rather than echoing discarded writes.
    always_comb begin
      data = '0;
      rdy  = 1'b0;
      if (addr == '0) begin
        rdy = 1'b1;
      end else if ({1'b0, addr} < REG_LIMIT) begin
        data = mem[addr];
        rdy  = ready[addr];
        if (rst_n) begin
          for (int p = WR_PORTS - 1; p >= 0; p--) begin
            if (wr_valid_i[p] && (wr_addr_i[p*W +: W] == addr)) begin
              data = wr_data_i[p*XLEN +: XLEN];
              rdy  = 1'b1;
            end
          end
        end
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = data;
    assign rd_ready_o[k]             = rdy;
  end

endmodule
`default_nettype wire

// File: tb/tb_physical_regfile_mp.sv
`default_nettype none
// tb_physical_regfile_mp: scoreboard bench for physical_regfile_mp; expected
// read results are queued as stimulus is driven and popped once outputs settle.
module tb_physical_regfile_mp;
  localparam int N  = 48;
  localparam int W  = 6;
  localparam int X  = 64;
  localparam int RP = 4;
  localparam int WP = 4;
  localparam int AP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RP*W-1:0] rd_addr;
  logic [RP*X-1:0] rd_data;
  logic [RP-1:0]   rd_ready;
  logic [WP-1:0]   wr_valid;
  logic [WP*W-1:0] wr_addr;
  logic [WP*X-1:0] wr_data;
  logic [AP-1:0]   alloc_valid;
  logic [AP*W-1:0] alloc_addr;
  logic            flush;
  logic            wr_conflict;

  physical_regfile_mp #(
    .REG_SIZE(N), .REG_SIZE_WIDTH(W), .XLEN(X),
    .RD_PORTS(RP), .WR_PORTS(WP), .ALLOC_PORTS(AP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_ready_o(rd_ready),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr),
    .flush_i(flush), .wr_conflict_o(wr_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         port;
    logic [X-1:0] data;
    logic       ready;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [X-1:0] m_mem [N];
  logic         m_rdy [N];
  logic         m_conf = 1'b0;

  task automatic idle();
    rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
    alloc_valid = '0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*W +: W] = W'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [X-1:0] d);
    wr_valid[p] = 1'b1; wr_addr[p*W +: W] = W'(a); wr_data[p*X +: X] = d;
  endtask

  task automatic set_alloc(input int p, input int a);
    alloc_valid[p] = 1'b1; alloc_addr[p*W +: W] = W'(a);
  endtask

  task automatic push(input string tag, input int port, input logic [X-1:0] d, input logic r);
    exp_t e;
    e.tag = tag; e.port = port; e.data = d; e.ready = r;
    q.push_back(e);
  endtask

  task automatic model_reset();
    for (int e = 0; e < N; e++) begin
      m_mem[e] = '0; m_rdy[e] = 1'b1;
    end
    m_conf = 1'b0;
  endtask

  task automatic model_rd(input int a, output logic [X-1:0] d, output logic r);
    d = '0; r = 1'b0;
    if (a == 0) r = 1'b1;
    else if (a < N) begin
      d = m_mem[a]; r = m_rdy[a];
      if (rst_n) begin
        for (int p = 0; p < WP; p++) begin
          if (wr_valid[p] && int'(wr_addr[p*W +: W]) == a) begin
            d = wr_data[p*X +: X]; r = 1'b1; break;
          end
        end
      end
    end
  endtask

  task automatic model_commit();
    bit done [N];
    logic c;
    int a;
    c = 1'b0;
    for (int e = 0; e < N; e++) done[e] = 1'b0;
    for (int p = 0; p < WP; p++) begin
      if (wr_valid[p]) begin
        a = int'(wr_addr[p*W +: W]);
        for (int o = 0; o < p; o++)
          if (wr_valid[o] && int'(wr_addr[o*W +: W]) == a && a != 0) c = 1'b1;
        if (a != 0 && a < N) begin
          if (!done[a]) begin m_mem[a] = wr_data[p*X +: X]; done[a] = 1'b1; end
          m_rdy[a] = 1'b1;
        end
      end
    end
    for (int p = 0; p < AP; p++) begin
      a = int'(alloc_addr[p*W +: W]);
      if (alloc_valid[p] && a != 0 && a < N) m_rdy[a] = 1'b0;
    end
    if (flush) for (int e = 0; e < N; e++) m_rdy[e] = 1'b1;
    m_conf = c;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++; $display("FAIL reset_conflict: got %b expected 0", wr_conflict);
    end
    for (int base = 0; base < N; base += RP) begin
      idle();
      for (int k = 0; k < RP; k++) begin
        set_rd(k, base + k);
        push("reset_read", k, '0, 1'b1);
      end
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
          failures++;
          $display("FAIL %s port%0d addr%0d: got data=%h ready=%b expected data=%h ready=%b",
                   e.tag, e.port, base + e.port, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
        end
      end
      tick();
    end
  endtask

  task automatic test_write_bypass();
    idle();
    set_wr(2, 17, 64'h1234_5678_9ABC_DEF0);
    set_rd(0, 17);
    push("bypass_same_cycle", 0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
    idle();
    set_rd(0, 17);
    push("bypass_from_array", 0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
  endtask

  task automatic test_conflict();
    idle();
    set_wr(0, 5, 64'hAA);
    set_wr(3, 5, 64'hBB);
    set_rd(0, 5);
    push("conflict_bypass", 0, 64'hAA, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++; $display("FAIL conflict_before: got %b expected 0", wr_conflict);
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b1) begin
      failures++; $display("FAIL conflict_pulse: got %b expected 1", wr_conflict);
    end
    idle();
    set_rd(0, 5);
    push("conflict_winner", 0, 64'hAA, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++; $display("FAIL conflict_after: got %b expected 0", wr_conflict);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    set_wr(0, 0, 64'hFFFF);
    set_wr(1, 0, 64'hFFFF);
    set_alloc(0, 0);
    set_rd(0, 0);
    set_rd(1, 0);
    push("zero_during_write", 0, '0, 1'b1);
    push("zero_during_write", 1, '0, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s port%0d: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, e.port, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++; $display("FAIL zero_conflict: got %b expected 0", wr_conflict);
    end
    idle();
    set_rd(2, 0);
    push("zero_after_write", 2, '0, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
  endtask

  task automatic test_scoreboard();
    logic [X-1:0] d1;
    logic [X-1:0] d2;
    d1 = 64'hCAFE_0000_0000_0030;
    d2 = 64'hBEEF_1111_2222_3333;
    // Each entry: stimulus kind, then the expected read of addr 30 in that cycle.
    for (int step = 0; step < 6; step++) begin
      idle();
      set_rd(1, 30);
      case (step)
        0: begin set_alloc(0, 30); push("sb_alloc_cycle", 1, '0, 1'b1); end
        1: push("sb_after_alloc", 1, '0, 1'b0);
        2: begin set_wr(1, 30, d1); push("sb_wb_bypass", 1, d1, 1'b1); end
        3: push("sb_after_wb", 1, d1, 1'b1);
        4: begin set_alloc(1, 30); set_wr(0, 30, d2); push("sb_alloc_wb_bypass", 1, d2, 1'b1); end
        default: push("sb_alloc_wins", 1, d2, 1'b0);
      endcase
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front(); checks++;
        if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
          failures++;
          $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                   e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    idle();
    set_alloc(0, 10);
    set_alloc(1, 11);
    tick();
    idle();
    set_rd(0, 10); set_rd(1, 11);
    push("flush_pre10", 0, '0, 1'b0);
    push("flush_pre11", 1, '0, 1'b0);
    flush = 1'b1;
    set_alloc(0, 12);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
    idle();
    set_rd(0, 10); set_rd(1, 11); set_rd(2, 12);
    push("flush_post10", 0, '0, 1'b1);
    push("flush_post11", 1, '0, 1'b1);
    push("flush_overrides_alloc", 2, '0, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [X-1:0] d;
    logic r;
    int a;
    for (int cyc = 0; cyc < 300; cyc++) begin
      idle();
      for (int p = 0; p < WP; p++) begin
        if ($urandom_range(0, 2) != 0) begin
          a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(48, 63)) : int'($urandom_range(0, 15));
          set_wr(p, a, {$urandom, $urandom});
        end
      end
      for (int p = 0; p < AP; p++)
        if ($urandom_range(0, 2) == 0) set_alloc(p, int'($urandom_range(0, 15)));
      flush = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < RP; k++) begin
        a = ($urandom_range(0, 2) == 0) ? int'(wr_addr[($urandom_range(0, WP-1))*W +: W])
                                        : int'($urandom_range(0, 63));
        set_rd(k, a);
        model_rd(a, d, r);
        push("random_read", k, d, r);
      end
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front(); checks++;
        if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
          failures++;
          $display("FAIL %s cyc%0d port%0d addr%0d: got data=%h ready=%b expected data=%h ready=%b",
                   e.tag, cyc, e.port, int'(rd_addr[e.port*W +: W]),
                   rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
        end
      end
      tick();
      checks++;
      if (wr_conflict !== m_conf) begin
        failures++;
        $display("FAIL random_conflict cyc%0d: got %b expected %b", cyc, wr_conflict, m_conf);
      end
    end
  endtask

  task automatic test_reset_midop();
    idle();
    set_wr(0, 20, 64'h1); set_wr(1, 20, 64'h2);
    tick();
    checks++;
    if (wr_conflict !== 1'b1) begin
      failures++; $display("FAIL midop_conflict_set: got %b expected 1", wr_conflict);
    end
    idle();
    for (int p = 0; p < WP; p++) set_wr(p, 20 + p, {$urandom, $urandom} | 64'h1);
    for (int k = 0; k < RP; k++) begin
      set_rd(k, 20 + k);
      push("midop_reset_read", k, '0, 1'b1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s port%0d: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, e.port, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    checks++;
    if (wr_conflict !== 1'b0) begin
      failures++; $display("FAIL midop_conflict_clear: got %b expected 0", wr_conflict);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    set_rd(0, 20); set_rd(1, 23);
    push("post_reset_read", 0, '0, 1'b1);
    push("post_reset_read", 1, '0, 1'b1);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front(); checks++;
      if (rd_data[e.port*X +: X] !== e.data || rd_ready[e.port] !== e.ready) begin
        failures++;
        $display("FAIL %s port%0d: got data=%h ready=%b expected data=%h ready=%b",
                 e.tag, e.port, rd_data[e.port*X +: X], rd_ready[e.port], e.data, e.ready);
      end
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
